iomem_dproc: RTL and testbench

Memory-mapped byte-stream processing peripheral on the SoC `iomem_*` bus, in the window decoded above 0x01FF_FFFF. The CPU pushes 8-bit samples into an input FIFO. A two-stage pipeline transforms them by the selected mode into an output FIFO, which the CPU drains. A level interrupt on `irq_5` signals that output data is waiting.

---
 rtl/dproc_pkg.sv | 48 ++++
 rtl/sync_fifo.sv | 49 ++++
 rtl/iomem_dproc.sv | 200 ++++++++++++++++++++
 tb/tb_iomem_dproc.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dproc_pkg.sv
// Shared definitions for the iomem_dproc byte-stream peripheral:
// register map, mode encodings, STATUS layout and the CTRL field struct.
package dproc_pkg;

  localparam logic [7:0] REG_CTRL   = 8'h00;
  localparam logic [7:0] REG_STATUS = 8'h04;
  localparam logic [7:0] REG_CFG    = 8'h08;
  localparam logic [7:0] REG_DIN    = 8'h0C;
  localparam logic [7:0] REG_DOUT   = 8'h10;

  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_INV  = 2'd1,
    MODE_THR  = 2'd2,
    MODE_HALF = 2'd3
  } mode_e;

  localparam int ST_IN_FULL   = 0;
  localparam int ST_IN_EMPTY  = 1;
  localparam int ST_OUT_FULL  = 2;
  localparam int ST_OUT_EMPTY = 3;
  localparam int ST_IRQ_PEND  = 4;
  localparam int ST_OVERFLOW  = 5;
  localparam int ST_UNDERFLOW = 6;
  localparam int ST_IN_CNT    = 8;
  localparam int ST_OUT_CNT   = 16;

  // CTRL[4:0]; flush is a write-only strobe and is never stored.
  typedef struct packed {
    logic  flush;
    logic  irq_en;
    mode_e mode;
    logic  enable;
  } ctrl_t;

  function automatic logic [7:0] apply_mode(input mode_e m, input logic [7:0] x,
                                            input logic [7:0] thresh);
    logic [7:0] y;
    case (m)
      MODE_PASS: y = x;
      MODE_INV:  y = ~x;
      MODE_THR:  y = (x >= thresh) ? 8'hFF : 8'h00;
      default:   y = {1'b0, x[7:1]};
    endcase
    return y;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered count; pointers wrap naturally since
// DEPTH is a power of two. Push when full and pop when empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/iomem_dproc.sv
// Memory-mapped byte-stream processor: bus decode/response, CTRL/CFG/sticky
// registers, input FIFO -> issue/transform -> stage 2 -> output FIFO, irq.
module iomem_dproc
  import dproc_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0300_0000,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        irq_out
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // Bus handshake: a request is accepted when valid, in the window and no
  // response is in progress; iomem_ready then pulses for exactly one cycle
  // with registered rdata, and the request's side effects apply that cycle.
  logic        accept;
  logic [7:0]  req_off;
  logic [3:0]  req_wstrb;
  logic [15:0] req_wdata;
  logic        req_pop;
  logic        req_under;
  logic        wr_cycle;
  logic [31:0] rd_word;
  logic [31:0] status_word;

  ctrl_t       ctrl;
  logic [7:0]  thresh;
  logic [7:0]  irq_level;
  logic        irq_pend;
  logic        overflow;
  logic        underflow;

  logic          in_push, in_pop, in_full, in_empty;
  logic          out_push, out_pop, out_full, out_empty;
  logic [7:0]    in_dout, out_dout;
  logic [CW-1:0] in_count, out_count;

  logic          flush;
  logic          issue;
  logic [CW:0]   occupancy;
  logic          s2_valid;
  logic [7:0]    s2_data;
  logic          irq_set;
  logic          unused_bits;

  assign unused_bits = ^iomem_wdata[31:16];
  assign accept   = iomem_valid && (iomem_addr[31:8] == BASE_ADDR[31:8]) && !iomem_ready;
  assign wr_cycle = iomem_ready && (req_wstrb != 4'h0);
  assign flush    = wr_cycle && (req_off == REG_CTRL) && req_wstrb[0] && req_wdata[4];

  always_comb begin
    status_word = '0;
    status_word[ST_IN_FULL]   = in_full;
    status_word[ST_IN_EMPTY]  = in_empty;
    status_word[ST_OUT_FULL]  = out_full;
    status_word[ST_OUT_EMPTY] = out_empty;
    status_word[ST_IRQ_PEND]  = irq_pend;
    status_word[ST_OVERFLOW]  = overflow;
    status_word[ST_UNDERFLOW] = underflow;
    status_word[ST_IN_CNT +: 8]  = 8'(in_count);
    status_word[ST_OUT_CNT +: 8] = 8'(out_count);
  end

  always_comb begin
    rd_word = '0;
    if (iomem_wstrb == 4'h0) begin
      case (iomem_addr[7:0])
        REG_CTRL:   rd_word = {28'h0, ctrl.irq_en, ctrl.mode, ctrl.enable};
        REG_STATUS: rd_word = status_word;
        REG_CFG:    rd_word = {16'h0, irq_level, thresh};
        REG_DOUT:   rd_word = out_empty ? 32'h0 : {24'h0, out_dout};
        default:    rd_word = '0;
      endcase
    end
  end

  // The pop/underflow decision is frozen at accept so it matches the data
  // returned, even if the output FIFO fills before the response cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      iomem_ready <= 1'b0;
      iomem_rdata <= '0;
      req_off     <= '0;
      req_wstrb   <= '0;
      req_wdata   <= '0;
      req_pop     <= 1'b0;
      req_under   <= 1'b0;
    end else begin
      iomem_ready <= accept;
      if (accept) begin
        iomem_rdata <= rd_word;
        req_off     <= iomem_addr[7:0];
        req_wstrb   <= iomem_wstrb;
        req_wdata   <= iomem_wdata[15:0];
        req_pop     <= (iomem_wstrb == 4'h0) && (iomem_addr[7:0] == REG_DOUT) && !out_empty;
        req_under   <= (iomem_wstrb == 4'h0) && (iomem_addr[7:0] == REG_DOUT) && out_empty;
      end else begin
        req_pop   <= 1'b0;
        req_under <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ctrl.enable <= 1'b0;
      ctrl.mode   <= MODE_PASS;
      ctrl.irq_en <= 1'b0;
      ctrl.flush  <= 1'b0;
      thresh      <= '0;
      irq_level   <= '0;
    end else if (wr_cycle) begin
      if (req_off == REG_CTRL && req_wstrb[0]) begin
        ctrl.enable <= req_wdata[0];
        ctrl.mode   <= mode_e'(req_wdata[2:1]);
        ctrl.irq_en <= req_wdata[3];
      end
      if (req_off == REG_CFG) begin
        if (req_wstrb[0]) thresh    <= req_wdata[7:0];
        if (req_wstrb[1]) irq_level <= req_wdata[15:8];
      end
    end
  end

  // Sticky bits: flush clears everything; otherwise a set beats a W1C.
  assign irq_set = (irq_level != 8'h0) && (8'(out_count) >= irq_level);

  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      irq_pend  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (irq_set) irq_pend <= 1'b1;
      else if (wr_cycle && req_off == REG_STATUS && req_wdata[ST_IRQ_PEND]) irq_pend <= 1'b0;

      if (wr_cycle && req_off == REG_DIN && in_full) overflow <= 1'b1;
      else if (wr_cycle && req_off == REG_STATUS && req_wdata[ST_OVERFLOW]) overflow <= 1'b0;

      if (iomem_ready && req_under) underflow <= 1'b1;
      else if (wr_cycle && req_off == REG_STATUS && req_wdata[ST_UNDERFLOW]) underflow <= 1'b0;
    end
  end

  assign irq_out = ctrl.irq_en & irq_pend;

  // Stage 1 is the issue cycle itself: the head sample is popped and
  // transformed with the current mode/thresh, then registered in stage 2.
  assign occupancy = {1'b0, out_count} + (CW+1)'(s2_valid);
  assign issue     = ctrl.enable && !in_empty && !flush && (occupancy < (CW+1)'(FIFO_DEPTH));
  assign in_push   = wr_cycle && (req_off == REG_DIN) && !in_full;
  assign in_pop    = issue;
  assign out_push  = s2_valid && !flush;
  assign out_pop   = iomem_ready && req_pop;

  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
    end else begin
      s2_valid <= issue;
      if (issue) s2_data <= apply_mode(ctrl.mode, in_dout, thresh);
    end
  end

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_in_fifo (
    .clk    (clk),
    .resetn (resetn),
    .flush  (flush),
    .push   (in_push),
    .pop    (in_pop),
    .din    (req_wdata[7:0]),
    .dout   (in_dout),
    .count  (in_count),
    .full   (in_full),
    .empty  (in_empty)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_out_fifo (
    .clk    (clk),
    .resetn (resetn),
    .flush  (flush),
    .push   (out_push),
    .pop    (out_pop),
    .din    (s2_data),
    .dout   (out_dout),
    .count  (out_count),
    .full   (out_full),
    .empty  (out_empty)
  );

endmodule

// File: tb/tb_iomem_dproc.sv
// Directed + randomized bench for iomem_dproc: drives the iomem bus, compares
// against a transform/queue reference model with immediate assertions.
module tb_iomem_dproc;
  localparam logic [31:0] BASE = 32'h0300_0000;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        resetn;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;
  logic        irq_out;

  int errors = 0;
  int checks = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] rd;

  iomem_dproc #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .iomem_valid (iomem_valid),
    .iomem_ready (iomem_ready),
    .iomem_wstrb (iomem_wstrb),
    .iomem_addr  (iomem_addr),
    .iomem_wdata (iomem_wdata),
    .iomem_rdata (iomem_rdata),
    .irq_out     (irq_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference transform, written from the mode definitions with arithmetic.
  function automatic logic [7:0] ref_xform(input int mode, input logic [7:0] x,
                                           input logic [7:0] thr);
    int v;
    case (mode)
      0: v = x;
      1: v = 255 - x;
      2: v = (x >= thr) ? 255 : 0;
      default: v = x / 2;
    endcase
    return 8'(v);
  endfunction

  task automatic bus(input logic [31:0] addr, input logic [3:0] strb,
                     input logic [31:0] wdata, output logic [31:0] rdata);
    logic got;
    got = 1'b0;
    rdata = '0;
    @(posedge clk); #1;
    iomem_valid = 1'b1;
    iomem_addr  = addr;
    iomem_wstrb = strb;
    iomem_wdata = wdata;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      if (iomem_ready) begin
        got = 1'b1;
        rdata = iomem_rdata;
        iomem_valid = 1'b0;
      end
    end
    iomem_valid = 1'b0;
    if (!got) check("bus_timeout", 32'(got), 32'd1);
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] data);
    logic [31:0] dummy;
    bus(BASE | 32'(off), 4'hF, data, dummy);
  endtask

  task automatic rdreg(input logic [7:0] off, output logic [31:0] data);
    bus(BASE | 32'(off), 4'h0, 32'h0, data);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int mode;
    int n;
    logic [7:0] thr;
    logic [7:0] x;

    resetn = 1'b0;
    iomem_valid = 1'b0;
    iomem_wstrb = '0;
    iomem_addr  = '0;
    iomem_wdata = '0;
    idle(3);
    check("reset_ready", 32'(iomem_ready), 32'd0);
    check("reset_rdata", iomem_rdata, 32'h0);
    check("reset_irq", 32'(irq_out), 32'd0);
    resetn = 1'b1;
    rdreg(8'h04, rd); check("reset_status", rd, 32'h0000_000A);
    rdreg(8'h00, rd); check("reset_ctrl", rd, 32'h0);

    // Byte strobes on CFG
    bus(BASE | 32'h08, 4'b0001, 32'h1234_5678, rd);
    rdreg(8'h08, rd); check("cfg_strb0", rd, 32'h0000_0078);
    bus(BASE | 32'h08, 4'b0010, 32'h0000_AB00, rd);
    rdreg(8'h08, rd); check("cfg_strb1", rd, 32'h0000_AB78);
    wr(8'h08, 32'h0);

    // Pass mode with latency view through STATUS
    wr(8'h00, 32'h1);
    wr(8'h0C, 32'h5A);
    rdreg(8'h04, rd); check("lat_status_n1", rd, 32'h0000_0108);
    rdreg(8'h04, rd); check("lat_status_n3", rd, 32'h0001_0002);
    wr(8'h0C, 32'h00);
    wr(8'h0C, 32'hFF);
    idle(4);
    rdreg(8'h10, rd); check("pass_0", rd, 32'h5A);
    rdreg(8'h10, rd); check("pass_1", rd, 32'h00);
    rdreg(8'h10, rd); check("pass_2", rd, 32'hFF);
    rdreg(8'h04, rd); check("pass_drained", rd, 32'h0000_000A);

    // Threshold, invert, halve
    wr(8'h00, 32'h5);
    wr(8'h08, 32'h80);
    wr(8'h0C, 32'h7F);
    wr(8'h0C, 32'h80);
    idle(4);
    rdreg(8'h10, rd); check("thr_7f", rd, 32'h00);
    rdreg(8'h10, rd); check("thr_80", rd, 32'hFF);
    wr(8'h00, 32'h3);
    wr(8'h0C, 32'h0F);
    idle(4);
    rdreg(8'h10, rd); check("inv_0f", rd, 32'hF0);
    wr(8'h00, 32'h7);
    wr(8'h0C, 32'h81);
    idle(4);
    rdreg(8'h10, rd); check("half_81", rd, 32'h40);

    // Randomized batches against the reference model
    for (int b = 0; b < 4; b++) begin
      mode = $urandom_range(0, 3);
      thr  = 8'($urandom_range(0, 255));
      n    = $urandom_range(1, 12);
      wr(8'h08, {24'h0, thr});
      wr(8'h00, 32'(1 + mode * 2));
      for (int i = 0; i < n; i++) begin
        x = 8'($urandom_range(0, 255));
        exp_q.push_back(ref_xform(mode, x, thr));
        wr(8'h0C, {24'h0, x});
      end
      idle(4);
      while (exp_q.size() > 0) begin
        rdreg(8'h10, rd);
        check("rand_data", rd, {24'h0, exp_q.pop_front()});
      end
      rdreg(8'h04, rd); check("rand_drained", rd, 32'h0000_000A);
    end

    // Outside the window: no response
    @(posedge clk); #1;
    iomem_valid = 1'b1;
    iomem_addr  = 32'h0200_0004;
    iomem_wstrb = 4'h0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("nohit_ready", 32'(iomem_ready), 32'd0);
    end
    iomem_valid = 1'b0;

    // Overflow / underflow / W1C with the pipeline stopped
    wr(8'h00, 32'h0);
    wr(8'h08, 32'h0);
    for (int i = 0; i < DEPTH + 1; i++) wr(8'h0C, 32'($urandom_range(0, 255)));
    rdreg(8'h04, rd); check("ovf_status", rd, 32'h0000_1029);
    rdreg(8'h10, rd); check("udf_data", rd, 32'h0);
    rdreg(8'h04, rd); check("udf_status", rd, 32'h0000_1069);
    wr(8'h04, 32'h60);
    rdreg(8'h04, rd); check("w1c_status", rd, 32'h0000_1009);
    wr(8'h00, 32'h10);
    rdreg(8'h04, rd); check("flush1_status", rd, 32'h0000_000A);

    // Interrupt level, set-beats-clear, release after drain
    wr(8'h00, 32'h9);
    wr(8'h08, 32'h0200);
    exp_q.push_back(8'($urandom_range(0, 255)));
    exp_q.push_back(8'($urandom_range(0, 255)));
    wr(8'h0C, {24'h0, exp_q[0]});
    wr(8'h0C, {24'h0, exp_q[1]});
    idle(4);
    check("irq_set", 32'(irq_out), 32'd1);
    wr(8'h04, 32'h10);
    rdreg(8'h04, rd); check("irq_w1c_held", rd, 32'h0002_0012);
    check("irq_still", 32'(irq_out), 32'd1);
    rdreg(8'h10, rd); check("irq_pop0", rd, {24'h0, exp_q.pop_front()});
    rdreg(8'h10, rd); check("irq_pop1", rd, {24'h0, exp_q.pop_front()});
    wr(8'h04, 32'h10);
    idle(1);
    check("irq_clear", 32'(irq_out), 32'd0);
    rdreg(8'h04, rd); check("irq_clear_status", rd, 32'h0000_000A);

    // Fill both FIFOs, then flush keeping enable
    wr(8'h08, 32'h0);
    wr(8'h00, 32'h1);
    for (int i = 0; i < DEPTH; i++) wr(8'h0C, 32'($urandom_range(0, 255)));
    idle(4);
    rdreg(8'h04, rd); check("fill_out", rd, 32'h0010_0006);
    wr(8'h00, 32'h0);
    for (int i = 0; i < DEPTH + 1; i++) wr(8'h0C, 32'($urandom_range(0, 255)));
    rdreg(8'h04, rd); check("fill_both", rd, 32'h0010_1025);
    wr(8'h00, 32'h11);
    rdreg(8'h04, rd); check("flush2_status", rd, 32'h0000_000A);
    rdreg(8'h00, rd); check("flush2_ctrl", rd, 32'h0000_0001);

    // Reset while a read is pending
    @(posedge clk); #1;
    iomem_valid = 1'b1;
    iomem_addr  = BASE | 32'h04;
    iomem_wstrb = 4'h0;
    resetn = 1'b0;
    @(posedge clk); #1;
    check("rst_pending_ready", 32'(iomem_ready), 32'd0);
    iomem_valid = 1'b0;
    resetn = 1'b1;
    rdreg(8'h00, rd); check("rst_ctrl", rd, 32'h0);
    rdreg(8'h04, rd); check("rst_status", rd, 32'h0000_000A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
